retire_unit: RTL and testbench
==============================

RETIRE_UNIT -- requirements
Module: retire_unit

Interface
REQ-001 Parameter: ISSUE_WIDTH, default 2, meaning the number of retire slots per cycle; slot 0 is the oldest.
REQ-002 Parameter: EXC_VECTOR, default 32'hBFC0_0380, meaning the exception redirect address.
REQ-003 Port: clk, input, 1, the single clock.
REQ-004 Port: resetn, input, 1, reset that is synchronous and active-low.
REQ-005 Port: ret_valid, input, ISSUE_WIDTH, per-slot retire valid from the ROB; the valid bits are contiguous from slot 0.
REQ-006 Port: ret_pc, input, ISSUE_WIDTH x 32, PC of each slot.
REQ-007 Port: ret_wen, input, ISSUE_WIDTH, register-write control bit of each slot.
REQ-008 Port: ret_dst, input, ISSUE_WIDTH x 5, architectural destination of each slot.
REQ-009 Port: ret_data, input, ISSUE_WIDTH x 32, result of each slot.
REQ-010 Port: ret_exc, input, ISSUE_WIDTH, exception flag of each slot.
REQ-011 Port: ret_taken, input, ISSUE_WIDTH, taken-branch flag of each slot.
REQ-012 Port: ret_target, input, ISSUE_WIDTH x 32, branch target of each slot.
REQ-013 Port: ret_ready, output, 1, the unit accepts slots this cycle.
REQ-014 Port: retired_cnt, output, $clog2(ISSUE_WIDTH+1), number of slots consumed this cycle; the ROB advances its head by this amount.
REQ-015 Port: rd_addr, input, 2 x 5, architectural register file read addresses.
REQ-016 Port: rd_data, output, 2 x 32, combinational read of the current register file state, with no write bypass.
REQ-017 Port: flush, output, 1, registered pipeline flush pulse.
REQ-018 Port: redirect_pc, output, 32, registered fetch redirect address; valid when flush is 1.
REQ-019 Port: epc, output, 32, registered PC of the last exception.

Function
REQ-020 The FSM SHALL have three states: RUN, WAIT_DS and FLUSH.
REQ-021 ret_ready SHALL be 1 in RUN and WAIT_DS and 0 in FLUSH; retired_cnt SHALL be 0 whenever ret_ready is 0.
REQ-022 In RUN, slots SHALL be processed in order 0 to N-1; each consumed slot with ret_wen=1, ret_exc=0 and ret_dst!=0 writes ret_data to the register file at the clock edge.
REQ-023 Writes to register 0 SHALL be dropped, and register 0 SHALL always read 0.
REQ-024 When two slots write the same register in one cycle, the higher-numbered slot SHALL win.
REQ-025 Exception in slot k in RUN:
- slot k is consumed but not written;
- slots after k are not consumed (retired_cnt = k+1);
- epc <= ret_pc[k];
- redirect_pc <= EXC_VECTOR;
- go to FLUSH.
REQ-026 Exception takes priority over a taken branch in the same slot.
REQ-027 Taken branch in slot k with slot k+1 valid:
- slots up to and including k+1 (the delay slot) are consumed and written;
- later slots are not consumed;
- redirect_pc <= ret_target[k];
- go to FLUSH.
REQ-028 Taken branch in the last valid slot: latch its target and PC, then go to WAIT_DS.
REQ-029 WAIT_DS with ret_valid[0]=0: stay in WAIT_DS; retired_cnt = 0.
REQ-030 WAIT_DS with ret_valid[0]=1 and ret_exc[0]=0:
- consume only slot 0 (retired_cnt = 1), write it;
- redirect_pc <= latched target;
- go to FLUSH.
REQ-031 WAIT_DS with ret_valid[0]=1 and ret_exc[0]=1:
- epc <= latched branch PC (exception in a delay slot);
- redirect_pc <= EXC_VECTOR;
- go to FLUSH.
REQ-032 A delay-slot exception in the same cycle as its branch (REQ-027 case) SHALL also set epc to the branch PC.
REQ-033 In FLUSH, flush SHALL be 1 for exactly one cycle; the next state SHALL be RUN.
REQ-034 flush SHALL be 0 in every other state.
REQ-035 Latency: flush SHALL be asserted one cycle after the triggering slot is consumed.

Reset
REQ-036 When resetn=0 at a clock edge, the unit SHALL load:
- state = RUN;
- all 32 registers = 0;
- flush = 0, redirect_pc = 0, epc = 0;
- latched target and PC = 0.
REQ-037 Reset SHALL override any pending WAIT_DS or FLUSH state, and no flush SHALL be emitted afterwards.
REQ-038 During reset, retired_cnt SHALL be 0 and ret_ready SHALL be 0.

Structure
REQ-039 A shared package retire_pkg SHALL hold the FSM state enum, the retire slot struct (pc, wen, dst, data, exc, taken, target) and EXC_VECTOR.
REQ-040 The register file SHALL be a sub-module named arf_regfile, with 32x32 storage, ISSUE_WIDTH write ports with priority to the highest-numbered port, and 2 asynchronous read ports.

Verification
REQ-041 Two plain writes: slot0 writes r3=0x11, slot1 writes r3=0x22. Required: rd r3 = 0x22; retired_cnt = 2; flush = 0.
REQ-042 Write to r0: slot0 writes r0=0xFF. Required: rd r0 = 0.
REQ-043 Exception in slot 0 at pc 0x80: required retired_cnt = 1 with no write; next cycle flush = 1, redirect_pc = 0xBFC00380, epc = 0x80.
REQ-044 Branch with delay slot in one group: slot0 is a taken branch to 0x200, slot1 writes r5=7. Required: r5 = 7; next cycle flush = 1, redirect_pc = 0x200.
REQ-045 Branch alone in slot 1 (pc 0x104, target 0x300), then 3 idle cycles, then slot0 has an exception. Required: WAIT_DS held across the idle cycles with retired_cnt = 0; then flush with redirect_pc = 0xBFC00380 and epc = 0x104.
REQ-046 resetn asserted while in WAIT_DS. Required: no flush is emitted; state is RUN; all registers are 0.

Source files
------------

// File: rtl/retire_pkg.sv
// Shared types and constants for the in-order retire unit and its register file.
package retire_pkg;

  localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    WAIT_DS = 2'd1,
    FLUSH   = 2'd2
  } retire_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic        wen;
    logic [4:0]  dst;
    logic [31:0] data;
    logic        exc;
    logic        taken;
    logic [31:0] target;
  } retire_slot_t;

  // A consumed slot updates architectural state only if it is a clean write to a real register.
  function automatic logic slot_writes(input retire_slot_t s);
    return s.wen && !s.exc && (s.dst != 5'd0);
  endfunction

endpackage

// File: rtl/retire_unit_if.sv
// ROB-to-retire handshake: per-slot retire bundle plus ready/consumed-count feedback.
interface retire_unit_if #(
  parameter int ISSUE_WIDTH = 2
);
  localparam int CNT_W = $clog2(ISSUE_WIDTH + 1);

  logic [ISSUE_WIDTH-1:0]       ret_valid;
  logic [ISSUE_WIDTH-1:0][31:0] ret_pc;
  logic [ISSUE_WIDTH-1:0]       ret_wen;
  logic [ISSUE_WIDTH-1:0][4:0]  ret_dst;
  logic [ISSUE_WIDTH-1:0][31:0] ret_data;
  logic [ISSUE_WIDTH-1:0]       ret_exc;
  logic [ISSUE_WIDTH-1:0]       ret_taken;
  logic [ISSUE_WIDTH-1:0][31:0] ret_target;
  logic                         ret_ready;
  logic [CNT_W-1:0]             retired_cnt;

  modport master (
    output ret_valid, ret_pc, ret_wen, ret_dst, ret_data, ret_exc, ret_taken, ret_target,
    input  ret_ready, retired_cnt
  );

  modport slave (
    input  ret_valid, ret_pc, ret_wen, ret_dst, ret_data, ret_exc, ret_taken, ret_target,
    output ret_ready, retired_cnt
  );

endinterface

// File: rtl/arf_regfile.sv
// Architectural register file: 32x32, multi-port write (highest port wins), 2 async reads.
module arf_regfile #(
  parameter int NUM_WR = 2
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [NUM_WR-1:0]       we,
  input  logic [NUM_WR-1:0][4:0]  waddr,
  input  logic [NUM_WR-1:0][31:0] wdata,
  input  logic [1:0][4:0]         raddr,
  output logic [1:0][31:0]        rdata
);

  logic [31:0] regs [32];

  // NOTE: the storage is reset because architectural state must read 0 after reset;
  // this forces flops rather than a RAM macro, which is acceptable at 32 entries.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      // Later non-blocking assignments win, giving the highest-numbered port priority.
      for (int p = 0; p < NUM_WR; p++) begin
        if (we[p] && (waddr[p] != 5'd0)) regs[waddr[p]] <= wdata[p];
      end
    end
  end

  always_comb begin
    for (int r = 0; r < 2; r++) begin
      rdata[r] = (raddr[r] == 5'd0) ? 32'd0 : regs[raddr[r]];
    end
  end

endmodule

// File: rtl/retire_unit.sv
// In-order retire stage: commits ROB slots, resolves exceptions and delayed branches, flushes.
module retire_unit
  import retire_pkg::*;
#(
  parameter int          ISSUE_WIDTH = 2,
  parameter logic [31:0] EXC_VECTOR  = retire_pkg::EXC_VECTOR
) (
  input  logic             clk,
  input  logic             resetn,
  retire_unit_if.slave     rif,
  input  logic [1:0][4:0]  rd_addr,
  output logic [1:0][31:0] rd_data,
  output logic             flush,
  output logic [31:0]      redirect_pc,
  output logic [31:0]      epc
);

  localparam int CNT_W = $clog2(ISSUE_WIDTH + 1);

  retire_state_e state_q, state_d;
  retire_slot_t  slot [ISSUE_WIDTH];

  logic [CNT_W-1:0]             slot_cnt;
  logic [ISSUE_WIDTH-1:0]       wr_en;
  logic [ISSUE_WIDTH-1:0][4:0]  wr_addr;
  logic [ISSUE_WIDTH-1:0][31:0] wr_data;
  logic        epc_set, redir_set, lat_set;
  logic [31:0] epc_nxt, redir_nxt, lat_pc_nxt, lat_tgt_nxt;
  logic [31:0] lat_pc_q, lat_tgt_q;
  logic        stop, ds_pending;
  logic [31:0] br_pc, br_tgt;

  always_comb begin
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      slot[k].pc     = rif.ret_pc[k];
      slot[k].wen    = rif.ret_wen[k];
      slot[k].dst    = rif.ret_dst[k];
      slot[k].data   = rif.ret_data[k];
      slot[k].exc    = rif.ret_exc[k];
      slot[k].taken  = rif.ret_taken[k];
      slot[k].target = rif.ret_target[k];
      wr_addr[k]     = rif.ret_dst[k];
      wr_data[k]     = rif.ret_data[k];
    end
  end

  // NOTE: state and datapath registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!resetn) state_q <= RUN;
    else         state_q <= state_d;
  end

  // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    slot_cnt    = '0;
    wr_en       = '0;
    epc_set     = 1'b0;
    epc_nxt     = '0;
    redir_set   = 1'b0;
    redir_nxt   = '0;
    lat_set     = 1'b0;
    lat_pc_nxt  = '0;
    lat_tgt_nxt = '0;
    stop        = 1'b0;
    ds_pending  = 1'b0;
    br_pc       = '0;
    br_tgt      = '0;
    unique case (state_q)
      RUN: begin
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
          if (!stop && rif.ret_valid[k]) begin
            slot_cnt = CNT_W'(k + 1);
            if (ds_pending) begin
              // Delay slot of a taken branch in the same group; it ends the group either way.
              stop      = 1'b1;
              state_d   = FLUSH;
              redir_set = 1'b1;
              if (slot[k].exc) begin
                epc_set   = 1'b1;
                epc_nxt   = br_pc;
                redir_nxt = EXC_VECTOR;
              end else begin
                wr_en[k]  = slot_writes(slot[k]);
                redir_nxt = br_tgt;
              end
            end else if (slot[k].exc) begin
              stop      = 1'b1;
              state_d   = FLUSH;
              epc_set   = 1'b1;
              epc_nxt   = slot[k].pc;
              redir_set = 1'b1;
              redir_nxt = EXC_VECTOR;
            end else begin
              wr_en[k] = slot_writes(slot[k]);
              if (slot[k].taken) begin
                ds_pending = 1'b1;
                br_pc      = slot[k].pc;
                br_tgt     = slot[k].target;
              end
            end
          end
        end
        if (ds_pending && !stop) begin
          lat_set     = 1'b1;
          lat_pc_nxt  = br_pc;
          lat_tgt_nxt = br_tgt;
          state_d     = WAIT_DS;
        end
      end
      WAIT_DS: begin
        if (rif.ret_valid[0]) begin
          slot_cnt  = CNT_W'(1);
          state_d   = FLUSH;
          redir_set = 1'b1;
          if (slot[0].exc) begin
            epc_set   = 1'b1;
            epc_nxt   = lat_pc_q;
            redir_nxt = EXC_VECTOR;
          end else begin
            wr_en[0]  = slot_writes(slot[0]);
            redir_nxt = lat_tgt_q;
          end
        end
      end
      FLUSH:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    rif.ret_ready   = resetn && (state_q != FLUSH);
    rif.retired_cnt = rif.ret_ready ? slot_cnt : '0;
    flush           = (state_q == FLUSH);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      epc         <= '0;
      redirect_pc <= '0;
      lat_pc_q    <= '0;
      lat_tgt_q   <= '0;
    end else begin
      if (epc_set)   epc         <= epc_nxt;
      if (redir_set) redirect_pc <= redir_nxt;
      if (lat_set) begin
        lat_pc_q  <= lat_pc_nxt;
        lat_tgt_q <= lat_tgt_nxt;
      end
    end
  end

  arf_regfile #(.NUM_WR(ISSUE_WIDTH)) u_arf (
    .clk    (clk),
    .resetn (resetn),
    .we     (wr_en),
    .waddr  (wr_addr),
    .wdata  (wr_data),
    .raddr  (rd_addr),
    .rdata  (rd_data)
  );

endmodule

// File: tb/tb_retire_unit.sv
// Directed bench for retire_unit: commits, r0, exceptions, delayed branches, reset in WAIT_DS.
module tb_retire_unit;

  logic             clk = 1'b0;
  logic             resetn;
  logic [1:0][4:0]  rd_addr;
  logic [1:0][31:0] rd_data;
  logic             flush;
  logic [31:0]      redirect_pc;
  logic [31:0]      epc;

  int passed = 0;
  int total  = 0;

  localparam logic [31:0] EXC = 32'hBFC0_0380;

  retire_unit_if #(.ISSUE_WIDTH(2)) bus ();

  retire_unit #(.ISSUE_WIDTH(2), .EXC_VECTOR(EXC)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .rif         (bus),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .flush       (flush),
    .redirect_pc (redirect_pc),
    .epc         (epc)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_bus();
    bus.ret_valid  = '0;
    bus.ret_pc     = '0;
    bus.ret_wen    = '0;
    bus.ret_dst    = '0;
    bus.ret_data   = '0;
    bus.ret_exc    = '0;
    bus.ret_taken  = '0;
    bus.ret_target = '0;
  endtask

  task automatic set_slot(input int k, input logic [31:0] pc, input logic wen,
                          input logic [4:0] dst, input logic [31:0] data,
                          input logic exc, input logic taken, input logic [31:0] target);
    bus.ret_valid[k]  = 1'b1;
    bus.ret_pc[k]     = pc;
    bus.ret_wen[k]    = wen;
    bus.ret_dst[k]    = dst;
    bus.ret_data[k]   = data;
    bus.ret_exc[k]    = exc;
    bus.ret_taken[k]  = taken;
    bus.ret_target[k] = target;
    #1;
  endtask

  task automatic check_reg(input string name, input logic [4:0] r, input logic [31:0] exp);
    rd_addr[0] = r;
    #1;
    total++;
    if (rd_data[0] !== exp) $display("FAIL %s: r%0d got %h want %h", name, r, rd_data[0], exp);
    else passed++;
  endtask

  task automatic check_cnt(input string name, input logic [1:0] exp);
    total++;
    if (bus.retired_cnt !== exp) $display("FAIL %s: retired_cnt got %0d want %0d", name, bus.retired_cnt, exp);
    else passed++;
  endtask

  task automatic check_flush(input string name, input logic exp_flush, input logic [31:0] exp_redir,
                             input logic check_epc, input logic [31:0] exp_epc);
    total++;
    if (flush !== exp_flush) $display("FAIL %s: flush got %b want %b", name, flush, exp_flush);
    else passed++;
    if (exp_flush) begin
      total++;
      if (redirect_pc !== exp_redir) $display("FAIL %s: redirect_pc got %h want %h", name, redirect_pc, exp_redir);
      else passed++;
    end
    if (check_epc) begin
      total++;
      if (epc !== exp_epc) $display("FAIL %s: epc got %h want %h", name, epc, exp_epc);
      else passed++;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    set_slot(0, 32'h10, 1'b1, 5'd1, 32'h1, 1'b0, 1'b0, 32'h0);
    set_slot(1, 32'h14, 1'b1, 5'd2, 32'h2, 1'b0, 1'b0, 32'h0);
    total++;
    if (bus.ret_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", bus.ret_ready);
    else passed++;
    check_cnt("reset_cnt", 2'd0);
    step();
    step();
    check_flush("reset_out", 1'b0, 32'h0, 1'b1, 32'h0);
    total++;
    if (redirect_pc !== 32'h0) $display("FAIL reset_redirect: got %h want 0", redirect_pc);
    else passed++;
    check_reg("reset_r1", 5'd1, 32'h0);
    clear_bus();
    resetn = 1'b1;
    #1;
    total++;
    if (bus.ret_ready !== 1'b1) $display("FAIL run_ready: got %b want 1", bus.ret_ready);
    else passed++;
  endtask

  task automatic test_plain_writes();
    set_slot(0, 32'h20, 1'b1, 5'd3, 32'h11, 1'b0, 1'b0, 32'h0);
    set_slot(1, 32'h24, 1'b1, 5'd3, 32'h22, 1'b0, 1'b0, 32'h0);
    check_cnt("plain_cnt", 2'd2);
    step();
    clear_bus();
    check_reg("plain_r3", 5'd3, 32'h22);
    check_flush("plain_noflush", 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic test_r0();
    set_slot(0, 32'h28, 1'b1, 5'd0, 32'hFF, 1'b0, 1'b0, 32'h0);
    check_cnt("r0_cnt", 2'd1);
    step();
    clear_bus();
    check_reg("r0_zero", 5'd0, 32'h0);
  endtask

  task automatic test_exc_slot0();
    set_slot(0, 32'h80, 1'b1, 5'd4, 32'h44, 1'b1, 1'b0, 32'h0);
    set_slot(1, 32'h84, 1'b1, 5'd6, 32'h66, 1'b0, 1'b0, 32'h0);
    check_cnt("exc0_cnt", 2'd1);
    step();
    check_flush("exc0_flush", 1'b1, EXC, 1'b1, 32'h80);
    check_cnt("exc0_flush_cnt", 2'd0);
    total++;
    if (bus.ret_ready !== 1'b0) $display("FAIL exc0_flush_ready: got %b want 0", bus.ret_ready);
    else passed++;
    clear_bus();
    check_reg("exc0_r4", 5'd4, 32'h0);
    check_reg("exc0_r6", 5'd6, 32'h0);
    step();
    check_flush("exc0_pulse_end", 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic test_branch_ds();
    set_slot(0, 32'h100, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 32'h200);
    set_slot(1, 32'h104, 1'b1, 5'd5, 32'h7, 1'b0, 1'b0, 32'h0);
    check_cnt("br_ds_cnt", 2'd2);
    step();
    clear_bus();
    check_flush("br_ds_flush", 1'b1, 32'h200, 1'b0, 32'h0);
    check_reg("br_ds_r5", 5'd5, 32'h7);
    step();
    check_flush("br_ds_pulse_end", 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic test_wait_ds_exc();
    set_slot(0, 32'h100, 1'b1, 5'd1, 32'h1, 1'b0, 1'b0, 32'h0);
    set_slot(1, 32'h104, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 32'h300);
    check_cnt("wds_br_cnt", 2'd2);
    step();
    clear_bus();
    #1;
    for (int i = 0; i < 3; i++) begin
      check_cnt("wds_idle_cnt", 2'd0);
      check_flush("wds_idle_noflush", 1'b0, 32'h0, 1'b0, 32'h0);
      step();
    end
    set_slot(0, 32'h108, 1'b1, 5'd2, 32'h9, 1'b1, 1'b0, 32'h0);
    check_cnt("wds_exc_cnt", 2'd1);
    step();
    clear_bus();
    check_flush("wds_exc_flush", 1'b1, EXC, 1'b1, 32'h104);
    check_reg("wds_r1", 5'd1, 32'h1);
    check_reg("wds_r2", 5'd2, 32'h0);
    step();
  endtask

  task automatic test_wait_ds_normal();
    set_slot(0, 32'h400, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 32'h500);
    check_cnt("wdsn_br_cnt", 2'd1);
    step();
    set_slot(0, 32'h404, 1'b1, 5'd7, 32'h77, 1'b0, 1'b0, 32'h0);
    set_slot(1, 32'h408, 1'b1, 5'd8, 32'h88, 1'b0, 1'b0, 32'h0);
    check_cnt("wdsn_ds_cnt", 2'd1);
    step();
    clear_bus();
    check_flush("wdsn_flush", 1'b1, 32'h500, 1'b0, 32'h0);
    check_reg("wdsn_r7", 5'd7, 32'h77);
    check_reg("wdsn_r8", 5'd8, 32'h0);
    step();
  endtask

  task automatic test_ds_exc_same_group();
    set_slot(0, 32'h600, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 32'h700);
    set_slot(1, 32'h604, 1'b1, 5'd9, 32'h99, 1'b1, 1'b0, 32'h0);
    check_cnt("dsx_cnt", 2'd2);
    step();
    clear_bus();
    check_flush("dsx_flush", 1'b1, EXC, 1'b1, 32'h600);
    check_reg("dsx_r9", 5'd9, 32'h0);
    step();
  endtask

  task automatic test_exc_priority();
    set_slot(0, 32'h800, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 32'h900);
    set_slot(1, 32'h804, 1'b1, 5'd11, 32'hB, 1'b0, 1'b0, 32'h0);
    check_cnt("prio_cnt", 2'd1);
    step();
    clear_bus();
    check_flush("prio_flush", 1'b1, EXC, 1'b1, 32'h800);
    check_reg("prio_r11", 5'd11, 32'h0);
    step();
  endtask

  task automatic test_exc_slot1();
    set_slot(0, 32'h900, 1'b1, 5'd10, 32'hA, 1'b0, 1'b0, 32'h0);
    set_slot(1, 32'h904, 1'b1, 5'd12, 32'hC, 1'b1, 1'b0, 32'h0);
    check_cnt("exc1_cnt", 2'd2);
    step();
    clear_bus();
    check_flush("exc1_flush", 1'b1, EXC, 1'b1, 32'h904);
    check_reg("exc1_r10", 5'd10, 32'hA);
    check_reg("exc1_r12", 5'd12, 32'h0);
    step();
  endtask

  task automatic test_reset_in_wait();
    int nonzero;
    set_slot(0, 32'hA00, 1'b1, 5'd13, 32'hD, 1'b0, 1'b0, 32'h0);
    set_slot(1, 32'hA04, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 32'hB00);
    step();
    clear_bus();
    set_slot(0, 32'hA08, 1'b1, 5'd14, 32'hE, 1'b0, 1'b0, 32'h0);
    resetn = 1'b0;
    #1;
    check_cnt("rstw_cnt", 2'd0);
    step();
    clear_bus();
    resetn = 1'b1;
    #1;
    check_flush("rstw_noflush0", 1'b0, 32'h0, 1'b0, 32'h0);
    nonzero = 0;
    for (int i = 0; i < 32; i++) begin
      rd_addr[0] = 5'(i);
      #1;
      if (rd_data[0] !== 32'h0) nonzero++;
    end
    total++;
    if (nonzero !== 0) $display("FAIL rstw_regs: %0d nonzero registers, want 0", nonzero);
    else passed++;
    step();
    check_flush("rstw_noflush1", 1'b0, 32'h0, 1'b0, 32'h0);
    set_slot(0, 32'hC00, 1'b1, 5'd2, 32'h5, 1'b0, 1'b0, 32'h0);
    set_slot(1, 32'hC04, 1'b1, 5'd3, 32'h6, 1'b0, 1'b0, 32'h0);
    check_cnt("rstw_run_cnt", 2'd2);
    step();
    clear_bus();
    check_flush("rstw_run_noflush", 1'b0, 32'h0, 1'b0, 32'h0);
    check_reg("rstw_r3", 5'd3, 32'h6);
  endtask

  initial begin
    resetn  = 1'b0;
    rd_addr = '0;
    clear_bus();
    step();
    test_reset();
    test_plain_writes();
    test_r0();
    test_exc_slot0();
    test_branch_ds();
    test_wait_ds_exc();
    test_wait_ds_normal();
    test_ds_exc_same_group();
    test_exc_priority();
    test_exc_slot1();
    test_reset_in_wait();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
